// File: rtl/cache_pkg.sv
// cache_pkg: shared widths and the per-way line record for the 2-way read cache
package cache_pkg;
  localparam int ADDR_W  = 17;
  localparam int SETS    = 64;
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - 1 - INDEX_W;
  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 2 * WORD_W;
  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [BLOCK_W-1:0] data;
  } line_t;
endpackage

// File: rtl/cache_way.sv
// cache_way: one way's valid/tag/data storage with a fill/clear write port and combinational match
module cache_way
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  input  logic               fill,
  input  logic               clear,
  input  logic [BLOCK_W-1:0] fill_data,
  output logic               valid,
  output logic               match,
  output logic [BLOCK_W-1:0] data
);
  line_t lines [SETS];
  // only valid bits are reset; tag/data contents are don't-care until filled
  always_ff @(posedge clk)
    if (!rst)
      for (int i = 0; i < SETS; i++) lines[i].valid <= 1'b0;
    else if (fill)
      lines[index] <= '{valid: 1'b1, tag: tag, data: fill_data};
    else if (clear)
      lines[index].valid <= 1'b0;
  // combinational lookup of the addressed set
  always_comb begin
    valid = lines[index].valid;
    match = valid && lines[index].tag == tag;
    data  = lines[index].data;
  end
endmodule

// File: rtl/cache.sv
// cache: 2-way set-associative read cache, 64 sets of two-word blocks; CACHE_PERF_CNT_EN adds hit/miss counters
module cache
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  address,
  input  logic [BLOCK_W-1:0] write_data,
  input  logic               cache_read_en,
  input  logic               cache_write_en,
  input  logic               invalidate,
  output logic [WORD_W-1:0]  read_data,
  output logic               hit
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);
  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] index;
  logic [SETS-1:0]    lru;
  logic               v0, v1, m0, m1, victim;
  logic [BLOCK_W-1:0] d0, d1, blk;
  assign tag   = address[ADDR_W-1:INDEX_W+1];
  assign index = address[INDEX_W:1];
  cache_way u_way0 (
    .clk       (clk),
    .rst       (rst),
    .index     (index),
    .tag       (tag),
    .fill      (cache_write_en && !victim),
    .clear     (!cache_write_en && invalidate && m0),
    .fill_data (write_data),
    .valid     (v0),
    .match     (m0),
    .data      (d0)
  );
  cache_way u_way1 (
    .clk       (clk),
    .rst       (rst),
    .index     (index),
    .tag       (tag),
    .fill      (cache_write_en && victim),
    .clear     (!cache_write_en && invalidate && m1),
    .fill_data (write_data),
    .valid     (v1),
    .match     (m1),
    .data      (d1)
  );
  // victim: an already-matching way first (no duplicate tags), then first invalid way, then LRU
  always_comb begin
    victim    = m0 ? 1'b0 : m1 ? 1'b1 : !v0 ? 1'b0 : !v1 ? 1'b1 : lru[index];
    hit       = cache_read_en && (m0 || m1);
    blk       = m0 ? d0 : d1;
    read_data = !hit ? '0 : address[0] ? blk[BLOCK_W-1:WORD_W] : blk[WORD_W-1:0];
  end
  // LRU bit names the next victim; fill beats invalidate beats read-hit
  always_ff @(posedge clk)
    if (!rst)
      lru <= '0;
    else if (cache_write_en)
      lru[index] <= !victim;
    else if (invalidate && (m0 || m1))
      lru[index] <= m1;
    else if (hit)
      lru[index] <= m0;
`ifdef CACHE_PERF_CNT_EN
  // one counter steps per enabled lookup, wrapping at 2^32
  always_ff @(posedge clk)
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (cache_read_en) begin
      if (hit) hit_count <= hit_count + 32'd1;
      else miss_count <= miss_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_cache.sv
// tb_cache: scoreboard-driven checks of lookup, fill, LRU, invalidate, priority and reset
module tb_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [16:0] address = '0;
  logic [63:0] write_data = '0;
  logic        cache_read_en = 1'b0, cache_write_en = 1'b0, invalidate = 1'b0;
  logic [31:0] read_data;
  logic        hit;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif
  int tests = 0, failed = 0;
  logic [32:0] sb [$];
  typedef struct {
    logic        r, re, we, inv;
    logic [16:0] a;
    logic [63:0] wd;
    logic        eh;
    logic [31:0] ed;
  } op_t;

  always #5 clk = ~clk;

  cache dut (
    .clk            (clk),
    .rst            (rst),
    .address        (address),
    .write_data     (write_data),
    .cache_read_en  (cache_read_en),
    .cache_write_en (cache_write_en),
    .invalidate     (invalidate),
    .read_data      (read_data),
    .hit            (hit)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  function automatic op_t mk(logic r, logic re, logic we, logic inv, logic [16:0] a,
                             logic [63:0] wd, logic eh, logic [31:0] ed);
    op_t o;
    o.r = r; o.re = re; o.we = we; o.inv = inv; o.a = a; o.wd = wd; o.eh = eh; o.ed = ed;
    return o;
  endfunction

  // each op is applied on the posedge that follows its mid-cycle sample
  task automatic req(input op_t o);
    @(posedge clk);
    #1;
    rst = o.r; cache_read_en = o.re; cache_write_en = o.we; invalidate = o.inv;
    address = o.a; write_data = o.wd;
    sb.push_back({o.eh, o.ed});
    @(negedge clk);
  endtask

  task automatic test_reset;
    op_t ops [$];
    logic [32:0] e;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    ops.push_back(mk(1, 1, 0, 0, 17'h00085, 64'h0, 0, 32'h0));
    foreach (ops[i]) begin
      req(ops[i]);
      e = sb.pop_front();
      tests++;
      if ({hit, read_data} !== e) begin
        failed++;
        $display("FAIL reset[%0d] addr=%h got hit=%b data=%h want hit=%b data=%h", i, ops[i].a, hit, read_data, e[32], e[31:0]);
      end
    end
`ifdef CACHE_PERF_CNT_EN
    tests++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      failed++;
      $display("FAIL reset_counters got hit_count=%0d miss_count=%0d want 0 0", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_fill;
    op_t ops [$];
    logic [32:0] e;
    ops.push_back(mk(1, 0, 1, 0, 17'h00085, 64'h0000BBBB_0000AAAA, 0, 32'h0));
    ops.push_back(mk(1, 1, 0, 0, 17'h00085, 64'h0, 1, 32'h0000BBBB));
    ops.push_back(mk(1, 1, 0, 0, 17'h00084, 64'h0, 1, 32'h0000AAAA));
    ops.push_back(mk(1, 0, 0, 0, 17'h00085, 64'h0, 0, 32'h0));
    foreach (ops[i]) begin
      req(ops[i]);
      e = sb.pop_front();
      tests++;
      if ({hit, read_data} !== e) begin
        failed++;
        $display("FAIL fill[%0d] addr=%h got hit=%b data=%h want hit=%b data=%h", i, ops[i].a, hit, read_data, e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_lru;
    op_t ops [$];
    logic [32:0] e;
    ops.push_back(mk(1, 0, 1, 0, 17'h00085, 64'h11111111_22222222, 0, 32'h0));
    ops.push_back(mk(1, 0, 1, 0, 17'h00105, 64'h77777777_88888888, 0, 32'h0));
    ops.push_back(mk(1, 1, 0, 0, 17'h00085, 64'h0, 1, 32'h11111111));
    ops.push_back(mk(1, 0, 1, 0, 17'h00185, 64'h99999999_AAAAAAAA, 0, 32'h0));
    ops.push_back(mk(1, 1, 0, 0, 17'h00085, 64'h0, 1, 32'h11111111));
    ops.push_back(mk(1, 1, 0, 0, 17'h00184, 64'h0, 1, 32'hAAAAAAAA));
    ops.push_back(mk(1, 1, 0, 0, 17'h00105, 64'h0, 0, 32'h0));
    ops.push_back(mk(1, 1, 0, 0, 17'h00104, 64'h0, 0, 32'h0));
    foreach (ops[i]) begin
      req(ops[i]);
      e = sb.pop_front();
      tests++;
      if ({hit, read_data} !== e) begin
        failed++;
        $display("FAIL lru[%0d] addr=%h got hit=%b data=%h want hit=%b data=%h", i, ops[i].a, hit, read_data, e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_invalidate;
    op_t ops [$];
    logic [32:0] e;
    ops.push_back(mk(1, 1, 0, 1, 17'h00084, 64'h0, 1, 32'h22222222));
    ops.push_back(mk(1, 1, 0, 0, 17'h00085, 64'h0, 0, 32'h0));
    ops.push_back(mk(1, 1, 0, 0, 17'h00185, 64'h0, 1, 32'h99999999));
    ops.push_back(mk(1, 0, 1, 0, 17'h00205, 64'h44444444_33333333, 0, 32'h0));
    ops.push_back(mk(1, 1, 0, 0, 17'h00205, 64'h0, 1, 32'h44444444));
    ops.push_back(mk(1, 1, 0, 0, 17'h00184, 64'h0, 1, 32'hAAAAAAAA));
    ops.push_back(mk(1, 1, 0, 0, 17'h00084, 64'h0, 0, 32'h0));
    foreach (ops[i]) begin
      req(ops[i]);
      e = sb.pop_front();
      tests++;
      if ({hit, read_data} !== e) begin
        failed++;
        $display("FAIL invalidate[%0d] addr=%h got hit=%b data=%h want hit=%b data=%h", i, ops[i].a, hit, read_data, e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_absent_invalidate;
    op_t ops [$];
    logic [32:0] e;
    ops.push_back(mk(1, 0, 0, 1, 17'h00305, 64'h0, 0, 32'h0));
    ops.push_back(mk(1, 1, 0, 0, 17'h00205, 64'h0, 1, 32'h44444444));
    ops.push_back(mk(1, 1, 0, 0, 17'h00185, 64'h0, 1, 32'h99999999));
    foreach (ops[i]) begin
      req(ops[i]);
      e = sb.pop_front();
      tests++;
      if ({hit, read_data} !== e) begin
        failed++;
        $display("FAIL absent_inv[%0d] addr=%h got hit=%b data=%h want hit=%b data=%h", i, ops[i].a, hit, read_data, e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_priority;
    op_t ops [$];
    logic [32:0] e;
    ops.push_back(mk(1, 1, 1, 1, 17'h00305, 64'h66666666_55555555, 0, 32'h0));
    ops.push_back(mk(1, 1, 0, 0, 17'h00305, 64'h0, 1, 32'h66666666));
    ops.push_back(mk(1, 1, 0, 0, 17'h00185, 64'h0, 1, 32'h99999999));
    ops.push_back(mk(1, 1, 0, 0, 17'h00205, 64'h0, 0, 32'h0));
    foreach (ops[i]) begin
      req(ops[i]);
      e = sb.pop_front();
      tests++;
      if ({hit, read_data} !== e) begin
        failed++;
        $display("FAIL priority[%0d] addr=%h got hit=%b data=%h want hit=%b data=%h", i, ops[i].a, hit, read_data, e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_mid_reset;
    op_t ops [$];
    logic [32:0] e;
    ops.push_back(mk(0, 1, 0, 0, 17'h00304, 64'h0, 1, 32'h55555555));
    ops.push_back(mk(1, 1, 0, 0, 17'h00305, 64'h0, 0, 32'h0));
    ops.push_back(mk(1, 1, 0, 0, 17'h00185, 64'h0, 0, 32'h0));
    ops.push_back(mk(1, 1, 0, 0, 17'h00084, 64'h0, 0, 32'h0));
    foreach (ops[i]) begin
      req(ops[i]);
      e = sb.pop_front();
      tests++;
      if ({hit, read_data} !== e) begin
        failed++;
        $display("FAIL mid_reset[%0d] addr=%h got hit=%b data=%h want hit=%b data=%h", i, ops[i].a, hit, read_data, e[32], e[31:0]);
      end
    end
`ifdef CACHE_PERF_CNT_EN
    tests++;
    if (hit_count !== 32'd0 || miss_count !== 32'd2) begin
      failed++;
      $display("FAIL mid_reset_counters got hit_count=%0d miss_count=%0d want 0 2", hit_count, miss_count);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_lru();
    test_invalidate();
    test_absent_invalidate();
    test_priority();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
